// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Purpose  : Groups the signals between the requesters, the response consumer
//            and alu_arbiter.
//            Request side : one valid/ready pair per requester, carrying
//                           operands A/B and the 3-bit ALU op code.
//            Response side: one valid/ready channel carrying the requester ID,
//                           the 64-bit result, the NZVC flags and an
//                           illegal-op marker.
// Modports : master - requesters and response consumer (testbench side)
//            slave  - alu_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
);
  // Request side, one lane per requester
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0][WIDTH-1:0] req_a;
  logic [NREQ-1:0][WIDTH-1:0] req_b;
  logic [NREQ-1:0][2:0]       req_cntrl;

  // Response side
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic                       rsp_id;
  logic [WIDTH-1:0]           rsp_result;
  logic                       rsp_negative;
  logic                       rsp_zero;
  logic                       rsp_overflow;
  logic                       rsp_carry_out;
  logic                       rsp_illegal;

  modport master (
    output req_valid, req_a, req_b, req_cntrl, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cntrl, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result,
           rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out, rsp_illegal
  );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter (with helper alu_arbiter_alu)
// Purpose  : Shares one combinational 64-bit ALU between two requesters.
//            Round-robin arbitration grants at most one request per cycle
//            whenever the one-entry response slot is free. The result and
//            flags of the granted operation are registered together with
//            the requester ID one cycle after the handshake.
// Ports    : clk        - rising-edge clock
//            reset_n    - asynchronous active-low reset
//            bus        - alu_arbiter_if.slave (request lanes + response)
//            grant_cnt0 - (perf option) handshakes accepted from requester 0
//            grant_cnt1 - (perf option) handshakes accepted from requester 1
//            stall_cnt  - (perf option) cycles with a pending request while
//                         the response slot was occupied
// Option   : define ALU_ARB_PERF_CNT_EN to add the saturating 32-bit
//            performance counters and their output ports.
// Op codes : 000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR,
//            001/111 illegal
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// Purely combinational ALU. Carry on SUB is the "no borrow" carry
// (A + ~B + 1), so 5 - 5 yields carry_out = 1.
// ----------------------------------------------------------------------------
module alu_arbiter_alu #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out,
  output logic             illegal
);
  localparam logic [2:0] OP_PASS_B = 3'b000;
  localparam logic [2:0] OP_ADD    = 3'b010;
  localparam logic [2:0] OP_SUB    = 3'b011;
  localparam logic [2:0] OP_AND    = 3'b100;
  localparam logic [2:0] OP_OR     = 3'b101;
  localparam logic [2:0] OP_XOR    = 3'b110;

  logic [WIDTH:0] sum;

  always_comb begin
    sum       = '0;
    result    = '0;
    overflow  = 1'b0;
    carry_out = 1'b0;
    illegal   = 1'b0;
    case (cntrl)
      OP_PASS_B: result = b;
      OP_ADD: begin
        sum       = {1'b0, a} + {1'b0, b};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        // Signed overflow: same-sign operands producing an opposite-sign sum
        overflow  = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sum       = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result    = sum[WIDTH-1:0];
        carry_out = sum[WIDTH];
        // Signed overflow: opposite-sign operands where the sign of A flips
        overflow  = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: illegal = 1'b1;
    endcase
  end

  assign negative = result[WIDTH-1];
  assign zero     = (result == '0);
endmodule

// ----------------------------------------------------------------------------
// Arbiter + response slot
// ----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH = 64,
  parameter int NREQ  = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus
`ifdef ALU_ARB_PERF_CNT_EN
  ,
  output logic [31:0]   grant_cnt0,
  output logic [31:0]   grant_cnt1,
  output logic [31:0]   stall_cnt
`endif
);
  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  // Registered state
  slot_state_e      slot_q,       slot_d;
  logic             rr_ptr_q,     rr_ptr_d;
  logic             rsp_id_q,     rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_neg_q,    rsp_neg_d;
  logic             rsp_zero_q,   rsp_zero_d;
  logic             rsp_ovf_q,    rsp_ovf_d;
  logic             rsp_carry_q,  rsp_carry_d;
  logic             rsp_ill_q,    rsp_ill_d;

  // Arbitration
  logic             slot_free;
  logic             gnt_any;
  logic             gnt_id;
  logic [NREQ-1:0]  grant;

  // Shared ALU datapath
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_cntrl;
  logic [WIDTH-1:0] alu_result;
  logic             alu_neg;
  logic             alu_zero;
  logic             alu_ovf;
  logic             alu_carry;
  logic             alu_ill;
  logic             op_is_arith;

  // --------------------------------------------------------------------------
  // Round-robin arbitration. reset_n gates the grant so req_ready drops
  // immediately (asynchronously) when reset asserts.
  // --------------------------------------------------------------------------
  always_comb begin
    slot_free = (slot_q == SLOT_EMPTY) || bus.rsp_ready;
    gnt_any   = 1'b0;
    gnt_id    = 1'b0;
    if (reset_n && slot_free) begin
      if (bus.req_valid[rr_ptr_q]) begin
        gnt_any = 1'b1;
        gnt_id  = rr_ptr_q;
      end else if (bus.req_valid[!rr_ptr_q]) begin
        gnt_any = 1'b1;
        gnt_id  = !rr_ptr_q;
      end
    end
    grant = gnt_any ? (NREQ'(1) << gnt_id) : '0;
  end

  assign bus.req_ready = grant;

  // The ALU always sees the lane selected by gnt_id; its output is only
  // captured when a grant actually happens.
  assign alu_a       = bus.req_a[gnt_id];
  assign alu_b       = bus.req_b[gnt_id];
  assign alu_cntrl   = bus.req_cntrl[gnt_id];
  assign op_is_arith = (alu_cntrl == OP_ADD) || (alu_cntrl == OP_SUB);

  alu_arbiter_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a         (alu_a),
    .b         (alu_b),
    .cntrl     (alu_cntrl),
    .result    (alu_result),
    .negative  (alu_neg),
    .zero      (alu_zero),
    .overflow  (alu_ovf),
    .carry_out (alu_carry),
    .illegal   (alu_ill)
  );

  // --------------------------------------------------------------------------
  // Response slot next state. A grant always (re)fills the slot, which also
  // covers the back-to-back case where the old entry drains this cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    slot_d       = slot_q;
    rr_ptr_d     = rr_ptr_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_neg_d    = rsp_neg_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_ill_d    = rsp_ill_q;
    if (gnt_any) begin
      slot_d       = SLOT_FULL;
      rr_ptr_d     = !gnt_id;
      rsp_id_d     = gnt_id;
      rsp_ill_d    = alu_ill;
      // Illegal ops report an all-zero result and flags; overflow/carry are
      // only meaningful for ADD/SUB.
      rsp_result_d = alu_ill ? '0 : alu_result;
      rsp_neg_d    = alu_neg  && !alu_ill;
      rsp_zero_d   = alu_zero && !alu_ill;
      rsp_ovf_d    = alu_ovf   && op_is_arith;
      rsp_carry_d  = alu_carry && op_is_arith;
    end else if ((slot_q == SLOT_FULL) && bus.rsp_ready) begin
      slot_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q       <= SLOT_EMPTY;
      rr_ptr_q     <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_neg_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_ovf_q    <= 1'b0;
      rsp_carry_q  <= 1'b0;
      rsp_ill_q    <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_neg_q    <= rsp_neg_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_ill_q    <= rsp_ill_d;
    end
  end

  assign bus.rsp_valid     = (slot_q == SLOT_FULL);
  assign bus.rsp_id        = rsp_id_q;
  assign bus.rsp_result    = rsp_result_q;
  assign bus.rsp_negative  = rsp_neg_q;
  assign bus.rsp_zero      = rsp_zero_q;
  assign bus.rsp_overflow  = rsp_ovf_q;
  assign bus.rsp_carry_out = rsp_carry_q;
  assign bus.rsp_illegal   = rsp_ill_q;

`ifdef ALU_ARB_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] grant_cnt0_q, grant_cnt0_d;
  logic [31:0] grant_cnt1_q, grant_cnt1_d;
  logic [31:0] stall_cnt_q,  stall_cnt_d;

  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    stall_cnt_d  = stall_cnt_q;
    if (grant[0] && (grant_cnt0_q != CNT_MAX)) grant_cnt0_d = grant_cnt0_q + 32'd1;
    if (grant[1] && (grant_cnt1_q != CNT_MAX)) grant_cnt1_d = grant_cnt1_q + 32'd1;
    if ((|bus.req_valid) && !slot_free && (stall_cnt_q != CNT_MAX))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
  assign stall_cnt  = stall_cnt_q;
`else
  // Performance counters not built in this configuration.
`endif
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 64-bit `alu` instance between two requesters (e.g. execute stage and a multi-cycle helper unit).
- Arbitrates round-robin with per-requester valid/ready handshakes.
- Computes the granted operation and captures result plus flags in a one-entry response register tagged with the requester ID.
- Response is drained through a single valid/ready channel.

Parameters:
- WIDTH, 64, operand/result width; must match the `alu` instance (only 64 supported).
- NREQ, 2, number of requesters; fixed at 2 (ID is 1 bit).

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid  input  2  per-requester request valid.
- req_ready  output  2  per-requester accept; handshake when valid & ready.
- req_a  input  2x64  operand A per requester.
- req_b  input  2x64  operand B per requester.
- req_cntrl  input  2x3  ALU op per requester (000 PASS_B, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR).
- rsp_valid  output  1  response register holds data.
- rsp_ready  input  1  consumer accepts response.
- rsp_id  output  1  requester index of the response.
- rsp_result  output  64  ALU result.
- rsp_negative, rsp_zero, rsp_overflow, rsp_carry_out  output  1 each  ALU flags captured with the result.
- rsp_illegal  output  1  request used an unsupported cntrl code (001 or 111).

Behaviour:
- Reset (async assert, sync deassert): rsp_valid=0, rsp_id=0, rsp_result=0, all flags 0, rsp_illegal=0, rr_ptr=0, req_ready=00.
- Response slot states:
  - EMPTY -> FULL on a grant.
  - FULL -> EMPTY on rsp_ready with no grant.
  - FULL -> FULL on rsp_ready with a simultaneous grant (back-to-back, one result per cycle).
- slot_free = !rsp_valid | rsp_ready.
- Arbitration, combinational each cycle:
  - If slot_free, grant one valid requester.
  - Priority starts at rr_ptr; if only one is valid it wins.
  - req_ready[i] = slot_free & grant[i]. At most one bit of req_ready is set.
  - req_ready is never asserted for a requester whose valid is low.
- On a grant:
  - Drive the granted A/B/cntrl into the `alu`.
  - Register result/flags, rsp_id=i, rsp_valid=1 at the next edge.
  - Set rr_ptr = ~i. rr_ptr is unchanged when there is no grant.
- Latency: 1 cycle from request handshake to rsp_valid.
- Requester rules:
  - Must hold A/B/cntrl stable while valid and not ready.
  - Deasserting valid before a handshake is allowed; nothing is issued.
- Illegal cntrl:
  - Request is accepted normally.
  - rsp_illegal=1, rsp_result=0, all four flags 0.
- Flags:
  - negative/zero are meaningful for every legal op.
  - overflow/carry_out are meaningful only for ADD/SUB. For logic/PASS_B ops they are forced to 0 in the register.
- Response hold: while rsp_valid & !rsp_ready, every rsp_* output is held stable and no grant occurs.
- Mid-operation reset: clears the response slot and pointer immediately; in-flight results are lost.

Optional Feature:
- Macro ALU_ARB_PERF_CNT_EN.
- Defined:
  - Adds outputs grant_cnt0, grant_cnt1 (32 bits each) counting handshakes per requester.
  - Adds stall_cnt (32 bits) counting cycles where some req_valid=1 and slot_free=0.
  - All counters reset to 0 and saturate at 0xFFFFFFFF (no wrap).
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Single request: req0 ADD, A=0x7FFF_FFFF_FFFF_FFFF, B=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, result=0x8000_0000_0000_0000, negative=1, overflow=1, carry_out=0, zero=0.
- Contention: both valid every cycle (req0 SUB A=5 B=5, req1 OR A=0xF0 B=0x0F), rsp_ready=1 -> grants alternate 0,1,0,1. Responses:
  - id0: result=0, zero=1, carry_out=1.
  - id1: result=0xFF.
- Backpressure: rsp_ready=0 after the first response -> req_ready=00, rsp_* stable for 5 cycles. Raise rsp_ready -> same-cycle new grant, back-to-back delivery.
- Illegal op: req1 cntrl=111, A=B=3 -> rsp_illegal=1, result=0, flags 0. A following legal req1 XOR A=3 B=3 -> zero=1, rsp_illegal=0.
- Reset mid-operation: assert reset_n=0 while rsp_valid=1 and both requesting -> rsp_valid=0 and req_ready=00 asynchronously. After release, first grant goes to req0.
- ALU_ARB_PERF_CNT_EN: 3 req0 and 2 req1 handshakes with 4 stalled cycles -> grant_cnt0=3, grant_cnt1=2, stall_cnt=4. Preload near max -> saturates at 0xFFFFFFFF.
